forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fwd_sel.sv | 24 ++
 rtl/forward_hazard_unit.sv | 111 +++++++++++
 tb/tb_forward_hazard_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - forwarding select codes and pipeline tracking entry shared by the hazard unit
package cpu_pkg;

    // Operand mux select codes for the EX stage; 2'b11 is never produced.
    localparam logic [1:0] FWD_SEL_REG = 2'b00;
    localparam logic [1:0] FWD_SEL_WB  = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM = 2'b10;

    // Register fields in tracking entries are held at this width; REG_AW of
    // the hazard unit must not exceed it (narrower addresses are zero-extended).
    localparam int unsigned TRK_AW = 8;

    // One shadow pipeline-stage entry.
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic [TRK_AW-1:0] rd;
    } trk_entry_t;

    localparam trk_entry_t TRK_BUBBLE = '0;

    // True when the entry will write register r and r is not x0.
    function automatic logic writes_reg(input trk_entry_t e, input logic [TRK_AW-1:0] r);
        return e.valid && e.regwrite && (e.rd != '0) && (e.rd == r);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - per-operand forwarding priority compare (MEM over WB over register file)
module fwd_sel
    import cpu_pkg::*;
(
    input  logic              ex_valid_i,
    input  logic [TRK_AW-1:0] ex_rs_i,
    input  trk_entry_t        mem_i,
    input  trk_entry_t        wb_i,
    output logic [1:0]        sel_o
);

    // The younger MEM result wins over WB; a bubble in EX never forwards.
    always_comb begin
        sel_o = FWD_SEL_REG;
        if (ex_valid_i) begin
            if (writes_reg(mem_i, ex_rs_i)) begin
                sel_o = FWD_SEL_MEM;
            end else if (writes_reg(wb_i, ex_rs_i)) begin
                sel_o = FWD_SEL_WB;
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - operand forwarding and load-use stall unit; FWD_STAT_EN adds a stall counter
module forward_hazard_unit
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
`ifdef FWD_STAT_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
`endif
    output logic              stall_o
);

    trk_entry_t        ex_q, ex_d, mem_q, wb_q;
    logic [TRK_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic [TRK_AW-1:0] id_rs1_w, id_rs2_w, id_rd_w;

    assign id_rs1_w = TRK_AW'(id_rs1_i);
    assign id_rs2_w = TRK_AW'(id_rs2_i);
    assign id_rd_w  = TRK_AW'(id_rd_i);

    // Load in EX whose destination is read by the instruction in ID.
    assign stall_o = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid_i &&
                     ((ex_q.rd == id_rs1_w) || (ex_q.rd == id_rs2_w));

    // EX takes the ID instruction, or a bubble when stalled, flushed or ID is empty.
    always_comb begin
        ex_d     = TRK_BUBBLE;
        ex_rs1_d = '0;
        ex_rs2_d = '0;
        if (id_valid_i && !stall_o && !flush_i) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
            ex_d.rd       = id_rd_w;
            ex_rs1_d      = id_rs1_w;
            ex_rs2_d      = id_rs2_w;
        end
    end

    // Shadow pipeline advance; MEM and WB move every cycle, even while stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q     <= TRK_BUBBLE;
            mem_q    <= TRK_BUBBLE;
            wb_q     <= TRK_BUBBLE;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= ex_q;
            wb_q     <= mem_q;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
        end
    end

    fwd_sel u_fwd_a (
        .ex_valid_i (ex_q.valid),
        .ex_rs_i    (ex_rs1_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .sel_o      (fwd_a_o)
    );

    fwd_sel u_fwd_b (
        .ex_valid_i (ex_q.valid),
        .ex_rs_i    (ex_rs2_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .sel_o      (fwd_b_o)
    );

`ifdef FWD_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count stall cycles, holding at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    // Counter width only matters when statistics are built in.
    localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - scoreboard bench for forward_hazard_unit
module tb_forward_hazard_unit;

    logic        clk_i         = 1'b0;
    logic        rst_n_i       = 1'b0;
    logic        id_valid_i    = 1'b0;
    logic [4:0]  id_rs1_i      = '0;
    logic [4:0]  id_rs2_i      = '0;
    logic [4:0]  id_rd_i       = '0;
    logic        id_regwrite_i = 1'b0;
    logic        id_memread_i  = 1'b0;
    logic        flush_i       = 1'b0;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic        stall_o;
`ifdef FWD_STAT_EN
    logic [15:0] stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    forward_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
`ifdef FWD_STAT_EN
        .stall_cnt_o   (stall_cnt_o),
`endif
        .stall_o       (stall_o)
    );

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic        s;
        logic [15:0] c;
        bit          late;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input string what, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", name, what, act, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        check(e.name, "fwd_a", {14'd0, fwd_a_o}, {14'd0, e.a});
        check(e.name, "fwd_b", {14'd0, fwd_b_o}, {14'd0, e.b});
        check(e.name, "stall", {15'd0, stall_o}, {15'd0, e.s});
`ifdef FWD_STAT_EN
        check(e.name, "stall_cnt", stall_cnt_o, e.c);
`endif
    endtask

    task automatic push_exp(input logic [1:0] ea, input logic [1:0] eb, input logic es,
                            input logic [15:0] ec, input bit late, input string name);
        exp_t e;
        e.a = ea; e.b = eb; e.s = es; e.c = ec; e.late = late; e.name = name;
        exp_q.push_back(e);
    endtask

    // One ID-stage cycle: apply inputs just after the edge, queue what this cycle must show.
    task automatic step(input logic rst, input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic rw, input logic mr, input logic fl,
                        input logic [1:0] ea, input logic [1:0] eb, input logic es,
                        input logic [15:0] ec, input string name);
        @(posedge clk_i);
        #1;
        rst_n_i       = rst;
        id_valid_i    = v;
        id_rd_i       = rd;
        id_rs1_i      = rs1;
        id_rs2_i      = rs2;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        push_exp(ea, eb, es, ec, 1'b0, name);
    endtask

    // Monitor: compare on the falling edge; a late entry is checked 3 time units later.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare(e);
                if (exp_q.size() > 0 && exp_q[0].late) begin
                    #3;
                    e = exp_q.pop_front();
                    compare(e);
                end
            end
        end
    end

    initial begin : driver
        //    rst v  rd  rs1 rs2 rw mr fl   a     b     s  cnt
        step(0, 0,  0,  0,  0, 0, 0, 0, 2'd0, 2'd0, 0, 0, "reset0");
        step(0, 0,  0,  0,  0, 0, 0, 0, 2'd0, 2'd0, 0, 0, "reset1");
        step(1, 1,  5,  1,  2, 1, 0, 0, 2'd0, 2'd0, 0, 0, "post_reset");
        step(1, 1,  6,  5,  3, 1, 0, 0, 2'd0, 2'd0, 0, 0, "add_in_ex");
        step(1, 0,  0,  0,  0, 0, 0, 0, 2'd2, 2'd0, 0, 0, "ex_mem_fwd_a");
        step(1, 1,  7,  0,  0, 1, 0, 0, 2'd0, 2'd0, 0, 0, "bubble_sel");
        step(1, 1,  8,  0,  0, 1, 0, 0, 2'd0, 2'd0, 0, 0, "c6");
        step(1, 1,  9,  1,  7, 1, 0, 0, 2'd0, 2'd0, 0, 0, "c7");
        step(1, 0,  0,  0,  0, 0, 0, 0, 2'd0, 2'd1, 0, 0, "wb_fwd_b");
        step(1, 1,  3,  0,  0, 1, 0, 0, 2'd0, 2'd0, 0, 0, "c9");
        step(1, 1,  3,  0,  0, 1, 0, 0, 2'd0, 2'd0, 0, 0, "c10");
        step(1, 1, 10,  3,  0, 1, 0, 0, 2'd0, 2'd0, 0, 0, "c11");
        step(1, 0,  0,  0,  0, 0, 0, 0, 2'd2, 2'd0, 0, 0, "mem_over_wb");
        step(1, 1,  4,  1,  0, 1, 1, 0, 2'd0, 2'd0, 0, 0, "lw_x4");
        step(1, 1, 11,  4,  2, 1, 0, 0, 2'd0, 2'd0, 1, 0, "load_use_stall");
        step(1, 1, 11,  4,  2, 1, 0, 0, 2'd0, 2'd0, 0, 1, "stall_one_cycle");
        step(1, 0,  0,  0,  0, 0, 0, 0, 2'd1, 2'd0, 0, 1, "load_use_wb_fwd");
        step(1, 1,  0,  0,  0, 1, 0, 0, 2'd0, 2'd0, 0, 1, "c17");
        step(1, 1, 12,  0,  0, 1, 0, 0, 2'd0, 2'd0, 0, 1, "c18");
        step(1, 1,  0,  1,  0, 1, 1, 0, 2'd0, 2'd0, 0, 1, "x0_not_fwd");
        step(1, 1, 13,  0,  0, 1, 0, 0, 2'd0, 2'd0, 0, 1, "x0_load_no_stall");
        step(1, 1,  9,  0,  0, 1, 1, 0, 2'd0, 2'd0, 0, 1, "lw_x9");
        step(1, 1, 14,  2,  9, 1, 0, 1, 2'd0, 2'd0, 1, 1, "flush_and_stall");
        step(1, 1, 15, 14,  0, 1, 0, 0, 2'd0, 2'd0, 0, 2, "flush_stall_bubble");
        step(1, 1, 16,  0,  0, 1, 1, 1, 2'd0, 2'd0, 0, 2, "flush_lw_x16");
        step(1, 1, 17, 16,  0, 1, 0, 0, 2'd0, 2'd0, 0, 2, "flushed_load_no_stall");
        step(1, 0,  0,  0,  0, 0, 0, 0, 2'd0, 2'd0, 0, 2, "c26");
        step(1, 1, 20,  0,  0, 1, 1, 0, 2'd0, 2'd0, 0, 2, "lw_x20");
        step(1, 1, 21, 20, 20, 1, 0, 0, 2'd0, 2'd0, 1, 2, "stall_before_reset");
        push_exp(2'd0, 2'd0, 1'b0, 16'd0, 1'b1, "reset_mid_stall");
        #6;
        rst_n_i = 1'b0;
        step(0, 1, 21, 20, 20, 1, 0, 0, 2'd0, 2'd0, 0, 0, "held_in_reset");
        step(1, 1, 21, 20, 20, 1, 0, 0, 2'd0, 2'd0, 0, 0, "first_after_reset");
        step(1, 0,  0,  0,  0, 0, 0, 0, 2'd0, 2'd0, 0, 0, "post_reset_nop");
        step(1, 1, 22, 21, 21, 1, 0, 0, 2'd0, 2'd0, 0, 0, "c32");
        step(1, 0,  0,  0,  0, 0, 0, 0, 2'd1, 2'd1, 0, 0, "wb_fwd_both");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
